// File: rtl/hdmi_text_pkg.sv
// Shared types and constants for the HDMI text controller register front-end.
package hdmi_text_pkg;

    localparam int         VRAM_WORDS  = 600;
    localparam int         CTRL_WORD   = VRAM_WORDS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_EXEC,
        W_RESP
    } wfsm_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MEM,
        R_DATA
    } rfsm_t;

    // Merge new_word into old_word, taking only the bytes whose strobe bit is set.
    function automatic logic [31:0] apply_strobes(input logic [31:0] old_word,
                                                  input logic [31:0] new_word,
                                                  input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hdmi_text_axi_regif.sv
// AXI4-Lite slave that maps the VRAM word port and the colour control register.
// Writes own the shared memory address for their single execute cycle; reads
// present the address during the AR handshake and sample VRAM one cycle later.
module hdmi_text_axi_regif
    import hdmi_text_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int VRAM_WORDS       = hdmi_text_pkg::VRAM_WORDS
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                    axi_awprot,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    output logic [9:0]                    mem_addr,
    output logic [3:0]                    mem_we,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata,
    output logic [31:0]                   ctrl_reg
);

    localparam logic [9:0] CTRL_IDX = 10'(VRAM_WORDS);

    wfsm_t       w_state, w_next;
    rfsm_t       r_state, r_next;
    logic        run_q;
    logic [9:0]  w_word_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;
    logic [9:0]  r_word_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [9:0]  aw_word;
    logic [9:0]  ar_word;
    logic        aw_hs, w_hs, ar_hs;
    logic        w_is_vram, w_is_ctrl;
    logic        unused_bits;

    assign aw_word   = axi_awaddr[11:2];
    assign ar_word   = axi_araddr[11:2];
    assign w_is_vram = (w_word_q < CTRL_IDX);
    assign w_is_ctrl = (w_word_q == CTRL_IDX);

    // Readies stay low while in reset and for the first cycle after it.
    assign axi_awready = run_q && ((w_state == W_IDLE) || (w_state == W_HAVE_D));
    assign axi_wready  = run_q && ((w_state == W_IDLE) || (w_state == W_HAVE_A));
    assign axi_arready = run_q && (r_state == R_IDLE) && (w_state != W_EXEC);
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign ar_hs       = axi_arvalid && axi_arready;

    assign axi_bvalid = (w_state == W_RESP);
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = (r_state == R_DATA);
    assign axi_rdata  = rdata_q;
    assign axi_rresp  = rresp_q;

    // The execute cycle owns the memory port; otherwise it follows the read side.
    assign mem_addr  = (w_state == W_EXEC) ? w_word_q :
                       (r_state == R_IDLE) ? ar_word : r_word_q;
    assign mem_we    = ((w_state == W_EXEC) && w_is_vram) ? w_strb_q : 4'h0;
    assign mem_wdata = w_data_q;

    assign unused_bits = ^{axi_awprot, axi_arprot,
                           axi_awaddr[C_AXI_ADDR_WIDTH-1:12], axi_awaddr[1:0],
                           axi_araddr[C_AXI_ADDR_WIDTH-1:12], axi_araddr[1:0]};

    // State registers for both channel FSMs plus the post-reset enable flag.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            run_q   <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            run_q   <= 1'b1;
        end
    end

    // Write FSM: collect AW and W in either order, execute once, then respond.
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_EXEC;
                else if (aw_hs)    w_next = W_HAVE_A;
                else if (w_hs)     w_next = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)       w_next = W_EXEC;
            W_HAVE_D: if (aw_hs)      w_next = W_EXEC;
            W_EXEC:                   w_next = W_RESP;
            W_RESP:   if (axi_bready) w_next = W_IDLE;
            default:                  w_next = W_IDLE;
        endcase
    end

    // Read FSM: one cycle for the VRAM to answer, then hold the beat until taken.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:   if (ar_hs)      r_next = R_MEM;
            R_MEM:                    r_next = R_DATA;
            R_DATA:   if (axi_rready) r_next = R_IDLE;
            default:                  r_next = R_IDLE;
        endcase
    end

    // Write datapath: hold address/data/strobes, apply ctrl writes, latch response.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_word_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= RESP_OKAY;
            ctrl_reg <= '0;
        end else begin
            if (aw_hs) w_word_q <= aw_word;
            if (w_hs) begin
                w_data_q <= axi_wdata;
                w_strb_q <= axi_wstrb;
            end
            if (w_state == W_EXEC) begin
                if (w_is_ctrl) ctrl_reg <= apply_strobes(ctrl_reg, w_data_q, w_strb_q);
                bresp_q <= (w_is_vram || w_is_ctrl) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read datapath: remember the word and capture the decoded read value.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_word_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (ar_hs) r_word_q <= ar_word;
            if (r_state == R_MEM) begin
                if (r_word_q < CTRL_IDX) begin
                    rdata_q <= mem_rdata;
                    rresp_q <= RESP_OKAY;
                end else if (r_word_q == CTRL_IDX) begin
                    rdata_q <= ctrl_reg;
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_text_axi_regif.sv
// Directed bench for the HDMI text AXI register front-end, with a small
// synchronous-read VRAM hung off the memory port.
module tb_hdmi_text_axi_regif;

    logic        axi_aclk;
    logic        axi_aresetn;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] ctrl_reg;

    int compared   = 0;
    int mismatched = 0;

    hdmi_text_axi_regif dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .ctrl_reg    (ctrl_reg)
    );

    // Free-running 100 MHz clock.
    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    // Byte-writable VRAM with one cycle of read latency.
    logic [31:0] vram [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = 32'h0;
        mem_rdata = 32'h0;
    end
    always @(posedge axi_aclk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) vram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= vram[mem_addr];
    end

    // Counts memory write cycles and bvalid pulses, sampled mid-cycle.
    int         we_pulses   = 0;
    int         b_rises     = 0;
    logic [9:0] we_addr_seen = 10'h0;
    logic [3:0] we_seen      = 4'h0;
    logic       bvalid_prev  = 1'b0;
    always @(negedge axi_aclk) begin
        if (mem_we != 4'h0) begin
            we_pulses    <= we_pulses + 1;
            we_addr_seen <= mem_addr;
            we_seen      <= mem_we;
        end
        if (axi_bvalid && !bvalid_prev) b_rises <= b_rises + 1;
        bvalid_prev <= axi_bvalid;
    end

    // Hard stop in case something outside the bounded waits stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at 500us, required to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got no handshake, required one within the cycle bound", name);
    endtask

    // Checks every output that has a defined reset value.
    task automatic check_reset_values(input string name);
        check_output({name, "_awready"}, 32'(axi_awready), 32'h0);
        check_output({name, "_wready"},  32'(axi_wready),  32'h0);
        check_output({name, "_arready"}, 32'(axi_arready), 32'h0);
        check_output({name, "_bvalid"},  32'(axi_bvalid),  32'h0);
        check_output({name, "_rvalid"},  32'(axi_rvalid),  32'h0);
        check_output({name, "_bresp"},   32'(axi_bresp),   32'h0);
        check_output({name, "_rresp"},   32'(axi_rresp),   32'h0);
        check_output({name, "_rdata"},   axi_rdata,        32'h0);
        check_output({name, "_mem_we"},  32'(mem_we),      32'h0);
        check_output({name, "_ctrl"},    ctrl_reg,         32'h0);
    endtask

    // Full AXI write; AW and W each start after their own delay, B is stalled b_stall cycles.
    task automatic axi_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_stall, input logic [1:0] exp_resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done    = 1'b0;
        w_done     = 1'b0;
        axi_awaddr = addr;
        axi_wdata  = data;
        axi_wstrb  = strb;
        for (n = 0; n < 40 && !(aw_done && w_done); n++) begin
            axi_awvalid = !aw_done && (n >= aw_dly);
            axi_wvalid  = !w_done && (n >= w_dly);
            #1;
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            @(negedge axi_aclk);
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            report_timeout({name, "_aw_w"});
            return;
        end
        #1;
        n = 0;
        while (!axi_bvalid && n < 20) begin
            @(negedge axi_aclk);
            #1;
            n++;
        end
        if (!axi_bvalid) begin
            report_timeout({name, "_b"});
            return;
        end
        check_output({name, "_bresp"}, 32'(axi_bresp), 32'(exp_resp));
        for (int k = 0; k < b_stall; k++) begin
            @(negedge axi_aclk);
            #1;
            check_output({name, "_bvalid_held"}, 32'(axi_bvalid), 32'h1);
            check_output({name, "_bresp_held"},  32'(axi_bresp),  32'(exp_resp));
            check_output({name, "_awready_in_b"}, 32'({axi_awready, axi_wready}), 32'h0);
        end
        axi_bready = 1'b1;
        @(negedge axi_aclk);
        axi_bready = 1'b0;
    endtask

    // Full AXI read; R is stalled r_stall cycles; optionally checks AR-to-rvalid latency.
    task automatic axi_read(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int r_stall, input bit check_latency);
        bit done;
        int n, lat;
        done       = 1'b0;
        axi_araddr = addr;
        for (n = 0; n < 20 && !done; n++) begin
            axi_arvalid = 1'b1;
            #1;
            done = axi_arready;
            @(negedge axi_aclk);
        end
        axi_arvalid = 1'b0;
        if (!done) begin
            report_timeout({name, "_ar"});
            return;
        end
        lat = 1;
        #1;
        while (!axi_rvalid && lat < 20) begin
            @(negedge axi_aclk);
            #1;
            lat++;
        end
        if (!axi_rvalid) begin
            report_timeout({name, "_r"});
            return;
        end
        if (check_latency) check_output({name, "_latency"}, 32'(lat), 32'd2);
        check_output({name, "_rdata"}, axi_rdata, exp_data);
        check_output({name, "_rresp"}, 32'(axi_rresp), 32'(exp_resp));
        for (int k = 0; k < r_stall; k++) begin
            @(negedge axi_aclk);
            #1;
            check_output({name, "_rvalid_held"}, 32'(axi_rvalid), 32'h1);
            check_output({name, "_rdata_held"},  axi_rdata,       exp_data);
            check_output({name, "_arready_in_r"}, 32'(axi_arready), 32'h0);
        end
        axi_rready = 1'b1;
        @(negedge axi_aclk);
        axi_rready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_strb;
        logic [1:0]  exp_bresp;
        logic [31:0] rd_addr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
        logic [31:0] exp_ctrl;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int we_before, b_before;
        bit hs;

        vecs[0] = '{32'h960, 32'h001F6000, 4'hF, 2'b00, 32'h960, 32'h001F6000, 2'b00, 32'h001F6000};
        vecs[1] = '{32'h014, 32'h11223344, 4'hF, 2'b00, 32'h014, 32'h11223344, 2'b00, 32'h001F6000};
        vecs[2] = '{32'h014, 32'h0000BB00, 4'h2, 2'b00, 32'h014, 32'h1122BB44, 2'b00, 32'h001F6000};
        vecs[3] = '{32'h964, 32'hDEADBEEF, 4'hF, 2'b10, 32'h964, 32'h00000000, 2'b10, 32'h001F6000};
        vecs[4] = '{32'h961, 32'hAABBCCDD, 4'h8, 2'b00, 32'h960, 32'hAA1F6000, 2'b00, 32'hAA1F6000};
        vecs[5] = '{32'h95C, 32'hCAFEF00D, 4'hF, 2'b00, 32'h95C, 32'hCAFEF00D, 2'b00, 32'hAA1F6000};
        vecs[6] = '{32'h020, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h020, 32'h00000000, 2'b00, 32'hAA1F6000};
        vecs[7] = '{32'hFFC, 32'h12345678, 4'hF, 2'b10, 32'hFFC, 32'h00000000, 2'b10, 32'hAA1F6000};

        axi_aresetn = 1'b0;
        axi_awaddr  = 32'h0;
        axi_awprot  = 3'h0;
        axi_awvalid = 1'b0;
        axi_wdata   = 32'h0;
        axi_wstrb   = 4'h0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_araddr  = 32'h0;
        axi_arprot  = 3'h0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;

        repeat (3) @(negedge axi_aclk);
        #1;
        check_reset_values("reset");
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        repeat (2) @(negedge axi_aclk);

        // Table: same-cycle AW/W writes each followed by a read-back.
        for (int i = 0; i < 8; i++) begin
            axi_write($sformatf("vec%0d_wr", i), vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_strb,
                      0, 0, 0, vecs[i].exp_bresp);
            axi_read($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rdata,
                     vecs[i].exp_rresp, 0, (i == 0));
            #1;
            check_output($sformatf("vec%0d_ctrl", i), ctrl_reg, vecs[i].exp_ctrl);
        end

        // AW leads W by three cycles: one VRAM write cycle at word 4, one bvalid pulse.
        #1;
        we_before = we_pulses;
        b_before  = b_rises;
        axi_write("aw_first", 32'h10, 32'hA5A5A5A5, 4'hF, 0, 3, 0, 2'b00);
        #1;
        check_output("aw_first_we_cycles", 32'(we_pulses - we_before), 32'd1);
        check_output("aw_first_we_addr",   32'(we_addr_seen), 32'd4);
        check_output("aw_first_we",        32'(we_seen), 32'hF);
        check_output("aw_first_b_pulses",  32'(b_rises - b_before), 32'd1);

        // W leads AW by three cycles.
        we_before = we_pulses;
        b_before  = b_rises;
        axi_write("w_first", 32'h10, 32'h5A5A5A5A, 4'hF, 3, 0, 0, 2'b00);
        #1;
        check_output("w_first_we_cycles", 32'(we_pulses - we_before), 32'd1);
        check_output("w_first_we_addr",   32'(we_addr_seen), 32'd4);
        check_output("w_first_b_pulses",  32'(b_rises - b_before), 32'd1);
        axi_read("w_first_rd", 32'h10, 32'h5A5A5A5A, 2'b00, 0, 1'b0);

        // Back-pressure on B and R for five cycles each.
        axi_write("b_stall", 32'h24, 32'h5A5A0000, 4'hF, 0, 0, 5, 2'b00);
        axi_read("r_stall", 32'h24, 32'h5A5A0000, 2'b00, 5, 1'b0);

        // Reset while the write FSM holds only the address.
        axi_awaddr  = 32'h1C;
        axi_awvalid = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            #1;
            hs = axi_awready;
            @(negedge axi_aclk);
        end
        axi_awvalid = 1'b0;
        if (!hs) report_timeout("rst_aw");
        #1;
        check_output("have_a_ready", 32'({axi_awready, axi_wready}), 32'h1);
        axi_aresetn = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        repeat (2) @(negedge axi_aclk);
        #1;
        we_before = we_pulses;
        axi_write("rst_recover", 32'h1C, 32'h77777777, 4'hF, 0, 0, 0, 2'b00);
        #1;
        check_output("rst_recover_we_cycles", 32'(we_pulses - we_before), 32'd1);
        check_output("rst_recover_we_addr",   32'(we_addr_seen), 32'd7);
        axi_read("rst_recover_rd", 32'h1C, 32'h77777777, 2'b00, 0, 1'b0);
        axi_read("vram_kept_rd", 32'h14, 32'h1122BB44, 2'b00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
